// File: rtl/dct_block_sequencer.sv
// DCT front-end sequencer: ping-pong 8x8 block store, butterfly-paired issue with
// datapath strobes, and framed collection of datapath results.
module dct_block_sequencer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned N          = 8,
  parameter int unsigned GAP_CYCLES = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_s_data,
  input  logic                  i_s_valid,
  output logic                  o_s_ready,
  output logic [DATA_WIDTH-1:0] o_dp_x,
  output logic                  o_dp_sum_diff_sel,
  output logic                  o_dp_load,
  output logic                  o_dp_tp_sel,
  input  logic [DATA_WIDTH-1:0] i_dp_y,
  input  logic                  i_dp_valid,
  output logic [DATA_WIDTH-1:0] o_m_data,
  output logic                  o_m_valid,
  output logic                  o_m_last,
  output logic                  o_busy,
  output logic                  o_err
);

  localparam int unsigned BlockSize = N * N;
  localparam int unsigned GapW      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {BankEmpty, BankFilling, BankFull, BankIssuing} bank_state_e;
  typedef enum logic [1:0] {StIdle, StIssue, StGap} state_e;

  logic [DATA_WIDTH-1:0] r_mem [2*BlockSize];
  logic [DATA_WIDTH-1:0] r_rd_data;
  bank_state_e           r_bank [2];
  bank_state_e           w_bank_nxt [2];
  logic                  r_wr_bank, r_rd_bank;
  logic [5:0]            r_wr_cnt;
  state_e                r_state, w_state_nxt;
  logic [6:0]            r_issue_cnt, w_issue_cnt_nxt;
  logic [GapW-1:0]       r_gap_cnt, w_gap_cnt_nxt;
  logic                  w_issue_start, w_issue_done;
  logic                  w_wr_fire, w_wr_last;
  logic [2:0]            w_col;
  logic [6:0]            w_rd_addr;
  logic                  r_s1_valid, r_s1_pass, r_s1_first;
  logic [5:0]            r_out_cnt;
  logic [1:0]            r_outstanding;
  logic                  w_last_result;

  // Write side: a bank accepts data only while it is empty or being filled.
  assign o_s_ready = ~i_rst & ((r_bank[r_wr_bank] == BankEmpty) ||
                               (r_bank[r_wr_bank] == BankFilling));
  assign w_wr_fire = i_s_valid & o_s_ready;
  assign w_wr_last = w_wr_fire & (r_wr_cnt == 6'(BlockSize - 1));

  // Butterfly pairing: k = 0..7 reads columns 0,7,1,6,2,5,3,4.
  assign w_col     = r_issue_cnt[0] ? {1'b1, ~r_issue_cnt[2:1]} : {1'b0, r_issue_cnt[2:1]};
  assign w_rd_addr = {r_rd_bank, r_issue_cnt[6:4], w_col};

  assign o_busy = ~i_rst & ((r_bank[0] != BankEmpty) || (r_bank[1] != BankEmpty) ||
                            (r_outstanding != 2'd0));

  // Issue FSM next state: IDLE -> ISSUE (128 beats) -> GAP (flush) -> IDLE.
  always_comb begin
    w_state_nxt     = r_state;
    w_issue_cnt_nxt = r_issue_cnt;
    w_gap_cnt_nxt   = r_gap_cnt;
    w_issue_start   = 1'b0;
    w_issue_done    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (r_bank[r_rd_bank] == BankFull) begin
          w_issue_start   = 1'b1;
          w_state_nxt     = StIssue;
          w_issue_cnt_nxt = '0;
        end
      end
      StIssue: begin
        if (r_issue_cnt == 7'd127) begin
          w_issue_done    = 1'b1;
          w_state_nxt     = StGap;
          w_gap_cnt_nxt   = '0;
          w_issue_cnt_nxt = '0;
        end else begin
          w_issue_cnt_nxt = r_issue_cnt + 7'd1;
        end
      end
      StGap: begin
        if (r_gap_cnt == GapW'(GAP_CYCLES - 1)) begin
          w_state_nxt = StIdle;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + GapW'(1);
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // Bank state next: write side only touches EMPTY/FILLING banks, read side FULL/ISSUING.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_bank_nxt[i] = r_bank[i];
      if (w_wr_fire && (r_wr_bank == 1'(i))) begin
        w_bank_nxt[i] = w_wr_last ? BankFull : BankFilling;
      end
      if (w_issue_start && (r_rd_bank == 1'(i))) begin
        w_bank_nxt[i] = BankIssuing;
      end
      if (w_issue_done && (r_rd_bank == 1'(i))) begin
        w_bank_nxt[i] = BankEmpty;
      end
    end
  end

  // Control state registers: FSM, counters, bank states and pointers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_issue_cnt <= '0;
      r_gap_cnt   <= '0;
      r_bank      <= '{BankEmpty, BankEmpty};
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_wr_cnt    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_issue_cnt <= w_issue_cnt_nxt;
      r_gap_cnt   <= w_gap_cnt_nxt;
      r_bank      <= w_bank_nxt;
      if (w_wr_fire) begin
        r_wr_cnt <= r_wr_cnt + 6'd1;
      end
      if (w_wr_last) begin
        r_wr_bank <= ~r_wr_bank;
      end
      if (w_issue_done) begin
        r_rd_bank <= ~r_rd_bank;
      end
    end
  end

  // Sample store: one write port, one registered read port.
  always_ff @(posedge i_clk) begin
    if (w_wr_fire) begin
      r_mem[{r_wr_bank, r_wr_cnt}] <= i_s_data;
    end
    r_rd_data <= r_mem[w_rd_addr];
  end

  // Strobe pipeline: stage 1 tracks the memory read, stage 2 drives the datapath.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_valid        <= 1'b0;
      r_s1_pass         <= 1'b0;
      r_s1_first        <= 1'b0;
      o_dp_x            <= '0;
      o_dp_sum_diff_sel <= 1'b0;
      o_dp_load         <= 1'b0;
      o_dp_tp_sel       <= 1'b0;
    end else begin
      r_s1_valid        <= (r_state == StIssue);
      r_s1_pass         <= r_issue_cnt[3];
      r_s1_first        <= (r_issue_cnt[2:0] == 3'd0);
      o_dp_x            <= r_s1_valid ? r_rd_data : '0;
      o_dp_sum_diff_sel <= r_s1_valid & r_s1_pass;
      o_dp_load         <= r_s1_valid & r_s1_first;
      o_dp_tp_sel       <= r_s1_valid & ~r_s1_pass;
    end
  end

  // Results arriving with nothing outstanding are not part of any frame.
  assign w_last_result = i_dp_valid & (r_outstanding != 2'd0) & (r_out_cnt == 6'd63);

  // Output framing, outstanding-block tracking and sticky error.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_m_data      <= '0;
      o_m_valid     <= 1'b0;
      o_m_last      <= 1'b0;
      o_err         <= 1'b0;
      r_out_cnt     <= '0;
      r_outstanding <= '0;
    end else begin
      o_m_data  <= i_dp_y;
      o_m_valid <= i_dp_valid;
      o_m_last  <= w_last_result;
      if (i_dp_valid && (r_outstanding == 2'd0)) begin
        o_err <= 1'b1;
      end
      if (i_dp_valid && (r_outstanding != 2'd0)) begin
        r_out_cnt <= r_out_cnt + 6'd1;
      end
      unique case ({w_issue_done, w_last_result})
        2'b10:   r_outstanding <= r_outstanding + 2'd1;
        2'b01:   r_outstanding <= r_outstanding - 2'd1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

endmodule
